// File: rtl/count_sequencer.sv
// count_sequencer: run/pause/stop controller for an up counter.
// A prescaler produces one-cycle count-enable ticks, gated by a start/pause/clear
// FSM. Counting stops (DONE) at the prescaler boundary after the counter, read
// back on `count`, has reached the target sampled when the run began.
//
// Ports
//   clk      in   1      system clock, posedge
//   reset_n  in   1      asynchronous active-low reset
//   start    in   1      1-cycle pulse: start or resume
//   pause    in   1      1-cycle pulse: toggle pause while running or paused
//   clear    in   1      1-cycle pulse: abort and zero the counter
//   target   in   WIDTH  stop value, sampled on entry into RUN from IDLE or DONE
//   count    in   WIDTH  counter's current value (feedback)
//   tick     out  1      count enable to the counter, 1-cycle pulse
//   cnt_clr  out  1      synchronous clear to the counter, 1-cycle pulse
//   running  out  1      high while in RUN
//   done     out  1      high while in DONE
//   state    out  2      IDLE=0, RUN=1, PAUSE=2, DONE=3
module count_sequencer #(
  parameter int unsigned DIV   = 25_000_000,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             cnt_clr,
  output logic             running,
  output logic             done,
  output logic [1:0]       state
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             tick_d, clr_d;
  logic             boundary;

  // State, prescaler, target and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tgt_q   <= '0;
      tick    <= 1'b0;
      cnt_clr <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tgt_q   <= tgt_d;
      tick    <= tick_d;
      cnt_clr <= clr_d;
      running <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  assign state    = state_q;
  assign boundary = (pre_q == PRE_LAST);

  // Next-state logic; priority clear > pause > start
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tgt_d   = tgt_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          clr_d = 1'b1;
        end else if (start) begin
          state_d = RUN;
          tgt_d   = target;
          pre_d   = '0;
        end
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          pre_d   = '0;
        end else if (pause) begin
          // prescaler holds so a resume continues the same tick period
          state_d = PAUSE;
        end else if (boundary) begin
          pre_d = '0;
          // count already shows every earlier tick, so equality means finished
          if (count == tgt_q) begin
            state_d = DONE;
          end else begin
            tick_d = 1'b1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          pre_d   = '0;
        end else if (pause || start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (clear) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (start) begin
          state_d = RUN;
          clr_d   = 1'b1;
          tgt_d   = target;
          pre_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
